// File: rtl/qlab5_mem_arb_pkg.sv
// Shared types and default widths for the on-chip RAM arbiter.
// Holds the master index enum and the per-master request bundle.
package qlab5_mem_arb_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } port_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic              wr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/qlab5_rr_arbiter2.sv
// Two-requester round-robin grant logic, purely combinational.
// Ports: req[1:0] requests, last_grant previous winner, grant[1:0] one-hot or zero.
module qlab5_rr_arbiter2
   import qlab5_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_e      last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // on a tie the master that did not win last time goes
         2'b11:   grant = (last_grant == M0) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/qlab5_onchip_mem_arbiter.sv
// Round-robin Avalon-MM arbiter sharing one 1024x32 on-chip RAM between m0/m1.
// Ports: clk, reset_n (sync, active-low), two Avalon slave ports m0_*/m1_*, RAM port mem_*.
module qlab5_onchip_mem_arbiter
   import qlab5_mem_arb_pkg::*;
#(
   parameter int ADDR_W = qlab5_mem_arb_pkg::ADDR_W,
   parameter int DATA_W = qlab5_mem_arb_pkg::DATA_W
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   logic [1:0] req;
   logic [1:0] arb_grant;
   logic [1:0] grant;
   logic       gnt_any;
   port_e      gnt_idx;
   mem_req_t   req0, req1, sel;
   port_e      last_grant;
   logic       rd_vld_q;
   port_e      rd_own_q;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   qlab5_rr_arbiter2 u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant)
   );

   // nothing is accepted while reset is asserted
   assign grant   = reset_n ? arb_grant : 2'b00;
   assign gnt_any = |grant;
   assign gnt_idx = grant[1] ? M1 : M0;

   // write takes priority if a master illegally raises both
   assign req0 = '{addr: m0_address, be: m0_byteenable,
                   wr: m0_write, wdata: m0_writedata};
   assign req1 = '{addr: m1_address, be: m1_byteenable,
                   wr: m1_write, wdata: m1_writedata};

   always_comb begin
      sel = '0;
      unique case (1'b1)
         grant[0]: sel = req0;
         grant[1]: sel = req1;
         default:  sel = '0;
      endcase
   end

   assign mem_address    = sel.addr;
   assign mem_byteenable = sel.be;
   assign mem_writedata  = sel.wdata;
   assign mem_write      = sel.wr;
   assign mem_chipselect = gnt_any;
   assign mem_clken      = reset_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_vld_q   <= 1'b0;
         rd_own_q   <= M0;
         last_grant <= M1;
      end else begin
         rd_vld_q <= gnt_any & ~sel.wr;
         if (gnt_any) begin
            rd_own_q   <= gnt_idx;
            last_grant <= gnt_idx;
         end
      end
   end

   assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
   assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;

   assign m0_readdatavalid = rd_vld_q & (rd_own_q == M0);
   assign m1_readdatavalid = rd_vld_q & (rd_own_q == M1);

   a_m0_rw_excl: assert property (@(posedge clk)
      disable iff (!reset_n) !(m0_read && m0_write));
   a_m1_rw_excl: assert property (@(posedge clk)
      disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_qlab5_onchip_mem_arbiter.sv
// Directed bench for qlab5_onchip_mem_arbiter with a behavioural 1024x32 RAM.
// Ports: none; drives the DUT masters and models the RAM behind mem_*.
module tb_qlab5_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram [1024];
   bit          ram_init;

   always #5 clk = ~clk;

   qlab5_onchip_mem_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // synchronous RAM, q registered from the address at the clock edge
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 1024; i++)
            ram[i] <= 32'hA500_0000 | 32'(i);
         ram_init <= 1'b1;
      end else if (mem_clken) begin
         if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b])
                  ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         mem_readdata <= ram[mem_address];
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m0_read = 0; m0_write = 0; m0_address = '0;
      m0_byteenable = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0;
      m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic drv(input int p, input logic rd, input logic wr,
                      input logic [9:0] a, input logic [3:0] be,
                      input logic [31:0] d);
      if (p == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a;
         m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a;
         m1_byteenable = be; m1_writedata = d;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      idle();
      m0_read = 1; m1_read = 1;

      repeat (3) begin
         tick(); #4;
         check("rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
         check("rst_cs", mem_chipselect, 1'b0);
         check("rst_clken", mem_clken, 1'b0);
         check("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      end

      // contention: both read, alternating grants starting with m0
      tick(); reset_n = 1'b1;
      drv(0, 1, 0, 10'd1, 4'hF, 0); drv(1, 1, 0, 10'd2, 4'hF, 0); #4;
      check("ct0_wait", {m1_waitrequest, m0_waitrequest}, 2'b10);
      check("ct0_addr", mem_address, 32'd1);
      check("ct0_clken", mem_clken, 1'b1);
      check("ct0_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick(); #4;
      check("ct1_wait", {m1_waitrequest, m0_waitrequest}, 2'b01);
      check("ct1_addr", mem_address, 32'd2);
      check("ct1_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("ct1_data", m0_readdata, 32'hA500_0001);
      tick(); #4;
      check("ct2_wait", {m1_waitrequest, m0_waitrequest}, 2'b10);
      check("ct2_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      check("ct2_data", m1_readdata, 32'hA500_0002);
      tick(); #4;
      check("ct3_wait", {m1_waitrequest, m0_waitrequest}, 2'b01);
      check("ct3_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("ct3_data", m0_readdata, 32'hA500_0001);
      tick(); idle(); #4;
      check("ct4_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);
      check("ct4_cs", mem_chipselect, 1'b0);
      check("ct4_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      check("ct4_data", m1_readdata, 32'hA500_0002);

      // single master write then read
      tick(); drv(0, 0, 1, 10'd5, 4'hF, 32'hDEAD_BEEF); #4;
      check("sw_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);
      check("sw_cs", mem_chipselect, 1'b1);
      check("sw_we", mem_write, 1'b1);
      check("sw_addr", mem_address, 32'd5);
      check("sw_wdata", mem_writedata, 32'hDEAD_BEEF);
      tick(); drv(0, 1, 0, 10'd5, 4'hF, 0); #4;
      check("sr_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);
      check("sr_we", mem_write, 1'b0);
      check("sr_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick(); idle(); #4;
      check("sr_rdv1", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("sr_data", m0_readdata, 32'hDEAD_BEEF);
      check("idle_addr", mem_address, 32'd0);

      // byte lanes on m1
      tick(); drv(1, 0, 1, 10'd9, 4'hF, 32'h1122_3344);
      tick(); drv(1, 0, 1, 10'd9, 4'b0001, 32'h0000_00AA); #4;
      check("be_lanes", mem_byteenable, 4'b0001);
      tick(); drv(1, 1, 0, 10'd9, 4'hF, 0);
      tick(); idle(); #4;
      check("be_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      check("be_data", m1_readdata, 32'h1122_33AA);

      // address boundary 1023 and 0
      tick(); drv(0, 0, 1, 10'd1023, 4'hF, 32'hCAFE_F00D);
      tick(); drv(0, 0, 1, 10'd0, 4'hF, 32'h1234_5678);
      tick(); drv(0, 1, 0, 10'd1023, 4'hF, 0); #4;
      check("bd_addr", mem_address, 32'd1023);
      tick(); drv(0, 1, 0, 10'd0, 4'hF, 0); #4;
      check("bd_rdv0", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("bd_hi", m0_readdata, 32'hCAFE_F00D);
      tick(); idle(); #4;
      check("bd_rdv1", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("bd_lo", m0_readdata, 32'h1234_5678);

      // reset while m1 reads; last winner was m0, reset must hand the tie back to m0
      tick(); reset_n = 1'b0; drv(1, 1, 0, 10'd9, 4'hF, 0); #4;
      check("mr_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
      check("mr_cs", mem_chipselect, 1'b0);
      check("mr_clken", mem_clken, 1'b0);
      tick(); reset_n = 1'b1;
      drv(0, 1, 0, 10'd5, 4'hF, 0); drv(1, 1, 0, 10'd9, 4'hF, 0); #4;
      check("mr_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      check("mr_tie", {m1_waitrequest, m0_waitrequest}, 2'b10);
      check("mr_addr", mem_address, 32'd5);
      tick(); idle(); #4;
      check("mr_rdv1", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      check("mr_data", m0_readdata, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
